// File: rtl/mux_pkg.sv
// Shared constants for the round-robin multiplexer/arbiter.
// Holds the select-mode encodings and the default channel count and
// data width, which the top uses as parameter defaults.
package mux_pkg;

  // Encodings of the mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Default geometry: four 8-bit channels
  localparam int DEF_NCH   = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first asserted request after the previously granted channel,
// wrapping modulo NCH.
// Ports:
//   req      - per-channel request vector
//   last_gnt - index of the channel granted most recently
//   any      - high when at least one request is asserted
//   gnt      - index of the chosen channel (only meaningful when any=1)
module rr_pick #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last_gnt,
  output logic            any,
  output logic [SELW-1:0] gnt
);

  logic [NCH-1:0] rotReq;
  int             startIdx;
  int             offset;

  // Rotate the request vector so the channel after last_gnt sits at bit 0,
  // priority-encode the lowest set bit, then rotate the index back.
  always_comb begin
    startIdx = (int'(last_gnt) + 1) % NCH;
    rotReq   = '0;
    for (int k = 0; k < NCH; k++) begin
      rotReq[k] = req[(k + startIdx) % NCH];
    end
    offset = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rotReq[k]) begin
        offset = k;
      end
    end
    any = |rotReq;
    gnt = SELW'((startIdx + offset) % NCH);
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel multiplexer with a registered output and valid/ready handshakes.
// In fixed mode the sel input picks the channel; in round-robin mode the
// channels are served fairly starting after the last granted one.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   mode       - 0 fixed select, 1 round-robin
//   sel        - channel index used in fixed mode
//   in_data    - packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel accept, one-hot or zero
//   out_data   - registered selected word
//   out_valid  - out_data/out_ch hold a pending word
//   out_ready  - downstream accept
//   out_ch     - channel that supplied out_data
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic [SELW-1:0]  outCh_q, outCh_d;
  logic [SELW-1:0]  lastGnt_q, lastGnt_d;

  logic             rrAny;
  logic [SELW-1:0]  rrGnt;
  logic             gntValid;
  logic [SELW-1:0]  gntIdx;
  logic             loadOk;
  logic             transfer;
  logic [WIDTH-1:0] selData;

  rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) uPick (
    .req      (in_valid),
    .last_gnt (lastGnt_q),
    .any      (rrAny),
    .gnt      (rrGnt)
  );

  // The output register can take a new word when empty or being drained.
  assign loadOk = !outValid_q || out_ready;

  // Grant selection. In fixed mode only sel may be granted; comparing
  // against each legal index makes an out-of-range sel yield no grant.
  always_comb begin
    gntValid = 1'b0;
    gntIdx   = '0;
    if (mode == MODE_RR) begin
      gntValid = rrAny;
      gntIdx   = rrGnt;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (int'(sel) == k && in_valid[k]) begin
          gntValid = 1'b1;
          gntIdx   = SELW'(k);
        end
      end
    end
  end

  // Ready goes only to the granted channel, and never during reset so
  // nothing is accepted in the reset cycle.
  always_comb begin
    in_ready = '0;
    selData  = '0;
    for (int k = 0; k < NCH; k++) begin
      in_ready[k] = !rst && gntValid && loadOk && (int'(gntIdx) == k);
      if (int'(gntIdx) == k) begin
        selData = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign transfer = |(in_valid & in_ready);

  // Next-state for the output register and the round-robin pointer.
  // A drain without a new load clears valid but keeps data and channel.
  always_comb begin
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outCh_d    = outCh_q;
    lastGnt_d  = lastGnt_q;
    if (transfer) begin
      outData_d  = selData;
      outValid_d = 1'b1;
      outCh_d    = gntIdx;
      if (mode == MODE_RR) begin
        lastGnt_d = gntIdx;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; the pointer resets to the last channel so that
  // channel 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outCh_q    <= '0;
      lastGnt_q  <= SELW'(NCH - 1);
    end else begin
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outCh_q    <= outCh_d;
      lastGnt_q  <= lastGnt_d;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign out_ch    = outCh_q;

endmodule
